instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/isa_pkg.sv | 35 +++
 rtl/sequencer_stack.sv | 54 +++++
 rtl/instruction_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: opcodes, program
// counter / stack pointer / instruction types and field extraction helpers.
package isa_pkg;

    localparam int PC_W     = 8;
    localparam int SP_W     = 8;
    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 4;
    localparam int IMM_W    = 12;

    typedef logic [PC_W-1:0]     pc_t;
    typedef logic [SP_W-1:0]     sp_t;
    typedef logic [INSTR_W-1:0]  instruction_t;
    typedef logic [IMM_W-1:0]    imm_t;

    // Instruction word layout: [15:12] opcode, [11:0] immediate.
    // Any opcode not listed below executes as a plain NOP.
    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 4'h0,
        OP_JMP  = 4'h1,
        OP_BRZ  = 4'h2,
        OP_CALL = 4'h3,
        OP_RET  = 4'h4,
        OP_HALT = 4'h5
    } opcode_e;

    function automatic opcode_e get_opcode(input instruction_t instr);
        return opcode_e'(instr[INSTR_W-1:IMM_W]);
    endfunction

    function automatic imm_t get_immediate(input instruction_t instr);
        return instr[IMM_W-1:0];
    endfunction

endpackage

// File: rtl/sequencer_stack.sv
// Call/return stack of return addresses. The pointer counts valid entries,
// so it equals STACK_DEPTH when full and 0 when empty; pushes into a full
// stack and pops from an empty stack leave the stack untouched.
module sequencer_stack
    import isa_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  pc_t  push_data,
    output pc_t  pop_data,
    output sp_t  sp,
    output logic full,
    output logic empty
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    pc_t              mem_r [STACK_DEPTH];
    sp_t              sp_r;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] top_idx_s;

    assign wr_idx_s  = sp_r[IDX_W-1:0];
    assign top_idx_s = IDX_W'(sp_r - sp_t'(1));
    assign full      = (sp_r == sp_t'(STACK_DEPTH));
    assign empty     = (sp_r == sp_t'(0));
    assign pop_data  = mem_r[top_idx_s];
    assign sp        = sp_r;

    // Stack pointer and storage update: clear rewinds, push writes the top, pop drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_r <= sp_t'(0);
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_r[i] <= pc_t'(0);
            end
        end else if (clear) begin
            sp_r <= sp_t'(0);
        end else if (push && !full) begin
            mem_r[wr_idx_s] <= push_data;
            sp_r            <= sp_r + sp_t'(1);
        end else if (pop && !empty) begin
            sp_r <= sp_r - sp_t'(1);
        end else begin
            sp_r <= sp_r;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches one instruction per FETCH/ISSUE pair from
// a synchronous program memory and broadcasts it to the cores together
// with the following PC and SP. Handles JMP, BRZ (taken when no core
// diverges), CALL/RET through a return-address stack, and HALT.
// Optional build macro SEQUENCER_SINGLE_STEP_EN adds a `step` input and a
// STEP_WAIT state that holds each instruction until step is seen.
module instruction_sequencer
    import isa_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef SEQUENCER_SINGLE_STEP_EN
    input  logic         step,
`endif
    output pc_t          imem_addr,
    output logic         imem_rd_en,
    input  instruction_t imem_rdata,
    output instruction_t instruction,
    output pc_t          next_program_counter,
    output sp_t          next_stack_pointer,
    output logic         global_enable,
    input  logic         diverge,
    output logic         busy,
    output logic         done,
    output logic         error
);

`ifdef SEQUENCER_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        DONE      = 3'd3,
        STEP_WAIT = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        DONE  = 3'd3
    } state_e;
`endif

    state_e       state_r, state_nx_s;
    pc_t          pc_r, pc_nx_s, pc_inc_s;
    logic         busy_r, done_r, error_r, rd_en_r;
    instruction_t instr_hold_r, instr_s;
    pc_t          npc_hold_r, npc_s;
    sp_t          nsp_hold_r, nsp_s;
    logic         ge_s, fault_s, halt_s;
    logic         push_s, pop_s, clear_s;
    pc_t          pop_data_s;
    sp_t          sp_s;
    logic         stack_full_s, stack_empty_s;

    sequencer_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .pop_data  (pop_data_s),
        .sp        (sp_s),
        .full      (stack_full_s),
        .empty     (stack_empty_s)
    );

    assign pc_inc_s = pc_r + pc_t'(1);

    // Next-state, next-PC/SP and broadcast decode; outside ISSUE the last broadcast is held.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        ge_s       = 1'b0;
        instr_s    = instr_hold_r;
        npc_s      = npc_hold_r;
        nsp_s      = nsp_hold_r;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        clear_s    = 1'b0;
        fault_s    = 1'b0;
        halt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = FETCH;
                    pc_nx_s    = pc_t'(0);
                    clear_s    = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FETCH: begin
`ifdef SEQUENCER_SINGLE_STEP_EN
                state_nx_s = STEP_WAIT;
`else
                state_nx_s = ISSUE;
`endif
            end
`ifdef SEQUENCER_SINGLE_STEP_EN
            // The read is repeated every waiting cycle so imem_rdata is
            // valid in whichever cycle ISSUE is finally entered.
            STEP_WAIT: begin
                if (step) begin
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = STEP_WAIT;
                end
            end
`endif
            ISSUE: begin
                instr_s = imem_rdata;
                npc_s   = pc_inc_s;
                nsp_s   = sp_s;
                case (get_opcode(imem_rdata))
                    OP_JMP: begin
                        npc_s = pc_t'(get_immediate(imem_rdata));
                    end
                    OP_BRZ: begin
                        if (!diverge) begin
                            npc_s = pc_t'(get_immediate(imem_rdata));
                        end else begin
                            npc_s = pc_inc_s;
                        end
                    end
                    OP_CALL: begin
                        if (stack_full_s) begin
                            fault_s = 1'b1;
                        end else begin
                            push_s = 1'b1;
                            npc_s  = pc_t'(get_immediate(imem_rdata));
                            nsp_s  = sp_s + sp_t'(1);
                        end
                    end
                    OP_RET: begin
                        if (stack_empty_s) begin
                            fault_s = 1'b1;
                        end else begin
                            pop_s = 1'b1;
                            npc_s = pop_data_s;
                            nsp_s = sp_s - sp_t'(1);
                        end
                    end
                    OP_HALT: begin
                        halt_s = 1'b1;
                    end
                    default: begin
                        npc_s = pc_inc_s;
                    end
                endcase
                if (fault_s || halt_s) begin
                    state_nx_s = DONE;
                end else begin
                    ge_s       = 1'b1;
                    pc_nx_s    = npc_s;
                    state_nx_s = FETCH;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, PC and registered status/strobe outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            pc_r    <= pc_t'(0);
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rd_en_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            done_r  <= (state_nx_s == DONE);
`ifdef SEQUENCER_SINGLE_STEP_EN
            rd_en_r <= (state_nx_s == FETCH) || (state_nx_s == STEP_WAIT);
`else
            rd_en_r <= (state_nx_s == FETCH);
`endif
        end
    end

    // Sticky stack-fault flag, cleared only when a new generation is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_r <= 1'b0;
        end else if (clear_s) begin
            error_r <= 1'b0;
        end else if (fault_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    // Keep the last broadcast visible between ISSUE cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_hold_r <= instruction_t'(0);
            npc_hold_r   <= pc_t'(0);
            nsp_hold_r   <= sp_t'(0);
        end else if (state_r == ISSUE) begin
            instr_hold_r <= instr_s;
            npc_hold_r   <= npc_s;
            nsp_hold_r   <= nsp_s;
        end else begin
            instr_hold_r <= instr_hold_r;
            npc_hold_r   <= npc_hold_r;
            nsp_hold_r   <= nsp_hold_r;
        end
    end

    assign imem_addr            = pc_r;
    assign imem_rd_en           = rd_en_r;
    assign instruction          = instr_s;
    assign next_program_counter = npc_s;
    assign next_stack_pointer   = nsp_s;
    assign global_enable        = ge_s;
    assign busy                 = busy_r;
    assign done                 = done_r;
    assign error                = error_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer (STACK_DEPTH = 2).
// An instruction-level model turns each program into per-cycle expectations
// (FETCH at cycle 2k, ISSUE at 2k+1, DONE after the final instruction), and
// one compare process checks the DUT against them every cycle of a run.
module tb_instruction_sequencer;
    import isa_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXC  = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         diverge;
    pc_t          imem_addr;
    logic         imem_rd_en;
    instruction_t imem_rdata = 16'h0000;
    instruction_t instruction;
    pc_t          next_program_counter;
    sp_t          next_stack_pointer;
    logic         global_enable;
    logic         busy;
    logic         done;
    logic         error;

    instruction_sequencer #(.STACK_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .imem_addr            (imem_addr),
        .imem_rd_en           (imem_rd_en),
        .imem_rdata           (imem_rdata),
        .instruction          (instruction),
        .next_program_counter (next_program_counter),
        .next_stack_pointer   (next_stack_pointer),
        .global_enable        (global_enable),
        .diverge              (diverge),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data one cycle after the read strobe.
    instruction_t mem [0:255];
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Per-cycle expectations produced by the model.
    logic         exp_ge   [MAXC];
    logic         exp_done [MAXC];
    logic         exp_busy [MAXC];
    logic         exp_rd   [MAXC];
    logic         exp_err  [MAXC];
    pc_t          exp_addr [MAXC];
    instruction_t exp_ins  [MAXC];
    pc_t          exp_npc  [MAXC];
    sp_t          exp_nsp  [MAXC];
    int           exp_last = 0;

    bit chk_en = 1'b0;
    int chk_c  = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 16'h5000;
    endtask

    // Instruction-level execution of mem[] from PC 0 with a constant diverge.
    task automatic build_model(input logic div);
        int pc;
        int sp;
        int stk [0:15];
        bit fin;
        pc  = 0;
        sp  = 0;
        fin = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            exp_ge[c] = 1'b0; exp_done[c] = 1'b0; exp_busy[c] = 1'b0;
            exp_rd[c] = 1'b0; exp_err[c] = 1'b0;  exp_addr[c] = 8'h00;
            exp_ins[c] = 16'h0000; exp_npc[c] = 8'h00; exp_nsp[c] = 8'h00;
        end
        exp_last = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            instruction_t ins;
            logic [3:0]   op;
            int           imm;
            int           npc;
            int           nsp;
            bit           stop;
            bit           flt;
            ins  = mem[pc];
            op   = ins[15:12];
            imm  = int'(ins[11:0]);
            npc  = (pc + 1) % 256;
            nsp  = sp;
            stop = 1'b0;
            flt  = 1'b0;
            case (op)
                OP_JMP:  npc = imm % 256;
                OP_BRZ:  if (!div) npc = imm % 256;
                OP_CALL: if (sp == DEPTH) flt = 1'b1;
                         else begin stk[sp] = (pc + 1) % 256; npc = imm % 256; nsp = sp + 1; end
                OP_RET:  if (sp == 0) flt = 1'b1;
                         else begin npc = stk[sp - 1]; nsp = sp - 1; end
                OP_HALT: stop = 1'b1;
                default: ;
            endcase
            exp_rd[2*k]     = 1'b1;
            exp_addr[2*k]   = pc_t'(pc);
            exp_busy[2*k]   = 1'b1;
            exp_busy[2*k+1] = 1'b1;
            exp_ge[2*k+1]   = !(stop || flt);
            exp_ins[2*k+1]  = ins;
            exp_npc[2*k+1]  = pc_t'(npc);
            exp_nsp[2*k+1]  = sp_t'(nsp);
            if (stop || flt) begin
                exp_done[2*k+2] = 1'b1;
                exp_busy[2*k+2] = 1'b1;
                exp_err[2*k+2]  = flt;
                exp_err[2*k+3]  = flt;
                exp_last        = 2*k + 3;
                fin             = 1'b1;
            end
            pc = npc;
            sp = nsp;
        end
    endtask

    // Compare process: every cycle of an active run against the model.
    always @(negedge clk) begin
        if (chk_en && chk_c <= exp_last) begin
            chk("global_enable", chk_c, global_enable, exp_ge[chk_c]);
            chk("done", chk_c, done, exp_done[chk_c]);
            chk("busy", chk_c, busy, exp_busy[chk_c]);
            chk("error", chk_c, error, exp_err[chk_c]);
            chk("imem_rd_en", chk_c, imem_rd_en, exp_rd[chk_c]);
            if (exp_rd[chk_c]) chk("imem_addr", chk_c, imem_addr, exp_addr[chk_c]);
            if (exp_ge[chk_c]) begin
                chk("instruction", chk_c, instruction, exp_ins[chk_c]);
                chk("next_program_counter", chk_c, next_program_counter, exp_npc[chk_c]);
                chk("next_stack_pointer", chk_c, next_stack_pointer, exp_nsp[chk_c]);
            end
            chk_c <= chk_c + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_prog(input logic div);
        diverge = div;
        pulse_start();
        chk_c  = 0;
        chk_en = 1'b1;
        for (int i = 0; i < 200 && chk_c <= exp_last; i++) @(negedge clk);
        #1;
        if (chk_c <= exp_last) chk("run_timeout", chk_c, 32'd0, 32'd1);
        chk_en = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        diverge = 1'b0;
        fill_halt();
        repeat (3) @(negedge clk);
        chk("rst_instruction", 0, instruction, 16'h0000);
        chk("rst_npc", 0, next_program_counter, 8'h00);
        chk("rst_nsp", 0, next_stack_pointer, 8'h00);
        chk("rst_global_enable", 0, global_enable, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        chk("rst_error", 0, error, 1'b0);
        chk("rst_rd_en", 0, imem_rd_en, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // NOP, NOP, HALT: two broadcasts (npc 1, 2), done 6 cycles after start.
        mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h5000;
        build_model(1'b0);
        chk("pin_p1_npc0", 1, exp_npc[1], 8'h01);
        chk("pin_p1_npc1", 3, exp_npc[3], 8'h02);
        chk("pin_p1_done", 6, exp_done[6], 1'b1);
        chk("pin_p1_halt_no_ge", 5, exp_ge[5], 1'b0);
        run_prog(1'b0);

        // JMP 5 -> next fetch at 5.
        fill_halt();
        mem[0] = 16'h1005;
        build_model(1'b0);
        chk("pin_jmp_npc", 1, exp_npc[1], 8'h05);
        chk("pin_jmp_addr", 2, exp_addr[2], 8'h05);
        run_prog(1'b0);

        // BRZ 9 with diverge=1 (not taken) and diverge=0 (taken).
        fill_halt();
        mem[0] = 16'h2009;
        build_model(1'b1);
        chk("pin_brz_div1", 1, exp_npc[1], 8'h01);
        run_prog(1'b1);
        build_model(1'b0);
        chk("pin_brz_div0", 1, exp_npc[1], 8'h09);
        run_prog(1'b0);

        // CALL 4, RET at 4, back to 1 (HALT).
        fill_halt();
        mem[0] = 16'h3004; mem[4] = 16'h4000;
        build_model(1'b0);
        chk("pin_call_sp", 1, exp_nsp[1], 8'h01);
        chk("pin_ret_sp", 3, exp_nsp[3], 8'h00);
        chk("pin_ret_addr", 4, exp_addr[4], 8'h01);
        run_prog(1'b0);

        // Three nested CALLs with depth 2: third faults.
        fill_halt();
        mem[0] = 16'h300A; mem[10] = 16'h3014; mem[20] = 16'h301E;
        build_model(1'b0);
        chk("pin_ovf_no_ge", 5, exp_ge[5], 1'b0);
        chk("pin_ovf_err", 6, exp_err[6], 1'b1);
        run_prog(1'b0);

        // RET with empty stack faults (error from previous run cleared by start).
        fill_halt();
        mem[0] = 16'h4000;
        build_model(1'b0);
        chk("pin_unf_done", 2, exp_done[2], 1'b1);
        run_prog(1'b0);

        // PC wrap 255 -> 0 is not an error; ends in a CALL overflow.
        fill_halt();
        mem[0] = 16'h30FF; mem[255] = 16'h0000;
        build_model(1'b0);
        chk("pin_wrap_npc", 3, exp_npc[3], 8'h00);
        chk("pin_wrap_err_clear", 7, exp_err[7], 1'b0);
        run_prog(1'b0);

        // Reset during ISSUE aborts at once, no done pulse; restart from PC 0.
        fill_halt();
        mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h5000;
        diverge = 1'b0;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ge", 1, global_enable, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ge", 1, global_enable, 1'b0);
        chk("mid_rst_busy", 1, busy, 1'b0);
        chk("mid_rst_done", 1, done, 1'b0);
        chk("mid_rst_rd_en", 1, imem_rd_en, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_done", i, done, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_busy", 0, busy, 1'b0);
        build_model(1'b0);
        run_prog(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
